// File: rtl/lzd_denorm_shift.sv
// lzd_denorm_shift
//
// Purpose:
//   Undoes a normalization. A normalized mantissa is right-shifted by a
//   count, which is normally the leading-zero count produced by the
//   detector tree, to bring it back to fixed-point alignment. A sticky bit
//   records whether any 1 bit was shifted out, for use in downstream
//   rounding. The shifter is a three-stage pipeline:
//     S1 shifts by 4*cnt[SW-1:2]
//     S2 shifts by 2*cnt[1]
//     S3 shifts by cnt[0]
//   Each side uses a valid/ready handshake. A beat moves forward whenever
//   the next stage is empty or is itself moving, so bubbles collapse even
//   while the output is stalled.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   in_valid    input beat present
//   in_ready    a beat can be accepted this cycle
//   in_data     normalized mantissa [W-1:0]
//   in_cnt      right-shift amount [SW-1:0], 0..W-1
//   in_zero     input is zero; forces the result to 0 with sticky=0
//   out_valid   output beat present
//   out_ready   downstream accepts the beat
//   out_data    in_data >> in_cnt (logical shift)
//   out_sticky  OR of all the bits shifted out
//   out_zero    registered copy of in_zero

module lzd_denorm_shift #(
   parameter  int W  = 32,
   localparam int SW = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [SW-1:0] in_cnt,
   input  logic          in_zero,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          out_sticky,
   output logic          out_zero
);

   // stage registers
   logic          v1, v2, v3;
   logic [W-1:0]  d1, d2, d3;
   logic [1:0]    c1;
   logic          c2;
   logic          st1, st2, st3;
   logic          z1, z2, z3;

   // handshake chain
   logic          adv1, adv2, adv3;
   logic          accept;

   assign adv3     = v3 & out_ready;
   assign adv2     = v2 & (~v3 | adv3);
   assign adv1     = v1 & (~v2 | adv2);
   assign in_ready = ~v1 | adv1;
   assign accept   = in_valid & in_ready;

   // stage 1 datapath: coarse shift by a multiple of four
   logic [SW-1:0] s1_amt;
   logic [W-1:0]  s1_data;
   logic          s1_sticky;

   always_comb begin
      s1_amt    = {in_cnt[SW-1:2], 2'b00};
      s1_data   = in_data >> s1_amt;
      // The bits that fall off are exactly those below bit position s1_amt.
      s1_sticky = |(in_data & ~({W{1'b1}} << s1_amt));
   end

   // stage 2 datapath: shift by 0 or 2
   logic [W-1:0]  s2_data;
   logic          s2_sticky;

   always_comb begin
      s2_data   = c1[1] ? (d1 >> 2) : d1;
      s2_sticky = st1 | (c1[1] & (|d1[1:0]));
   end

   // stage 3 datapath: shift by 0 or 1. A zero input overrides everything.
   logic [W-1:0]  s3_data;
   logic          s3_sticky;

   always_comb begin
      s3_data   = c2 ? (d2 >> 1) : d2;
      s3_sticky = st2 | (c2 & d2[0]);
      if (z2) begin
         s3_data   = '0;
         s3_sticky = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1  <= 1'b0;
         d1  <= '0;
         c1  <= '0;
         st1 <= 1'b0;
         z1  <= 1'b0;
      end else if (accept) begin
         v1  <= 1'b1;
         d1  <= s1_data;
         c1  <= in_cnt[1:0];
         st1 <= s1_sticky;
         z1  <= in_zero;
      end else if (adv1) begin
         v1  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2  <= 1'b0;
         d2  <= '0;
         c2  <= 1'b0;
         st2 <= 1'b0;
         z2  <= 1'b0;
      end else if (adv1) begin
         v2  <= 1'b1;
         d2  <= s2_data;
         c2  <= c1[0];
         st2 <= s2_sticky;
         z2  <= z1;
      end else if (adv2) begin
         v2  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3  <= 1'b0;
         d3  <= '0;
         st3 <= 1'b0;
         z3  <= 1'b0;
      end else if (adv2) begin
         v3  <= 1'b1;
         d3  <= s3_data;
         st3 <= s3_sticky;
         z3  <= z2;
      end else if (adv3) begin
         v3  <= 1'b0;
      end
   end

   assign out_valid  = v3;
   assign out_data   = d3;
   assign out_sticky = st3;
   assign out_zero   = z3;

endmodule

// File: tb/tb_lzd_denorm_shift.sv
// tb_lzd_denorm_shift
//
// Purpose:
//   Directed testbench for lzd_denorm_shift with W=32. The main body is a
//   table of hand-computed vectors, each sent as a single beat. Separate
//   sequences cover reset, backpressure and reset mid-flight. The
//   backpressure stream uses a small arithmetic model for its expected data.

module tb_lzd_denorm_shift;

   localparam int W  = 32;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [SW-1:0] in_cnt;
   logic          in_zero;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_sticky;
   logic          out_zero;

   int n_pass  = 0;
   int n_total = 0;

   lzd_denorm_shift #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_cnt     (in_cnt),
      .in_zero    (in_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sticky (out_sticky),
      .out_zero   (out_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference for the streaming test: logical shift, with sticky set when
   // any bit below position cnt is 1.
   function automatic logic [W:0] model(input logic [W-1:0] d, input int c);
      logic [W-1:0] mask;
      mask = (32'h1 << c) - 32'h1;
      return {d >> c, |(d & mask)};
   endfunction

   // Present one beat, then wait a bounded number of cycles for it to
   // appear at the output. lat counts edges from presentation to out_valid.
   task automatic send_one(input logic [W-1:0] d, input logic [SW-1:0] c, input logic z,
                           output logic [W-1:0] od, output logic os, output logic oz,
                           output int lat);
      in_valid = 1'b1;
      in_data  = d;
      in_cnt   = c;
      in_zero  = z;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      od = out_data;
      os = out_sticky;
      oz = out_zero;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [W-1:0]  data;
      logic [SW-1:0] cnt;
      logic          zero;
      logic [W-1:0]  exp_data;
      logic          exp_sticky;
      logic          exp_zero;
   } vec_t;

   vec_t vecs [15];

   initial begin
      logic [W-1:0] od;
      logic         os, oz;
      int           lat;
      int           sent, got, first_block;
      logic         prev_stall, gap_seen;
      logic [W-1:0] prev_d;
      logic         prev_s, prev_z;
      logic [W:0]   m;

      vecs[0]  = '{32'h80000000, 5'd0,  1'b0, 32'h80000000, 1'b0, 1'b0};
      vecs[1]  = '{32'hC0000001, 5'd5,  1'b0, 32'h06000000, 1'b1, 1'b0};
      vecs[2]  = '{32'hC0000000, 5'd5,  1'b0, 32'h06000000, 1'b0, 1'b0};
      vecs[3]  = '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001, 1'b1, 1'b0};
      vecs[4]  = '{32'hFFFFFFFF, 5'd3,  1'b1, 32'h00000000, 1'b0, 1'b1};
      vecs[5]  = '{32'h12345678, 5'd0,  1'b0, 32'h12345678, 1'b0, 1'b0};
      vecs[6]  = '{32'h12345678, 5'd4,  1'b0, 32'h01234567, 1'b1, 1'b0};
      vecs[7]  = '{32'h12345670, 5'd4,  1'b0, 32'h01234567, 1'b0, 1'b0};
      vecs[8]  = '{32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b0, 1'b0};
      vecs[9]  = '{32'h00000003, 5'd1,  1'b0, 32'h00000001, 1'b1, 1'b0};
      vecs[10] = '{32'h00000002, 5'd2,  1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[11] = '{32'hA5A5A5A5, 5'd8,  1'b0, 32'h00A5A5A5, 1'b1, 1'b0};
      vecs[12] = '{32'h00000100, 5'd8,  1'b0, 32'h00000001, 1'b0, 1'b0};
      vecs[13] = '{32'h7FFFFFFF, 5'd31, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[14] = '{32'h00000000, 5'd0,  1'b1, 32'h00000000, 1'b0, 1'b1};

      // reset, with in_valid held high throughout
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hFFFFFFFF;
      in_cnt    = 5'd7;
      in_zero   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_out_valid",  {63'd0, out_valid}, 64'd0);
      chk("rst_out_data",   {32'd0, out_data}, 64'd0);
      chk("rst_out_sticky", {63'd0, out_sticky}, 64'd0);
      chk("rst_out_zero",   {63'd0, out_zero}, 64'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      lat = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      chk("post_rst_nothing_emerges", 64'(lat), 64'd0);

      // table-driven single beats
      for (int i = 0; i < 15; i++) begin
         send_one(vecs[i].data, vecs[i].cnt, vecs[i].zero, od, os, oz, lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
         chk($sformatf("vec%0d_data", i),   {32'd0, od}, {32'd0, vecs[i].exp_data});
         chk($sformatf("vec%0d_sticky", i), {63'd0, os}, {63'd0, vecs[i].exp_sticky});
         chk($sformatf("vec%0d_zero", i),   {63'd0, oz}, {63'd0, vecs[i].exp_zero});
      end

      // backpressure: 6 beats, out_ready low for cycles 2..8
      sent = 0; got = 0; first_block = -1;
      prev_stall = 1'b0; gap_seen = 1'b0;
      prev_d = '0; prev_s = 1'b0; prev_z = 1'b0;
      in_zero = 1'b0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         out_ready = !(c >= 2 && c <= 8);
         in_valid  = (sent < 6);
         in_data   = 32'hF0000000;
         in_cnt    = sent[SW-1:0];
         #1;
         if (prev_stall)
            chk($sformatf("bp_stable_c%0d", c),
                {29'd0, out_valid, out_sticky, out_zero, out_data},
                {29'd0, 1'b1, prev_s, prev_z, prev_d});
         if (in_valid && !in_ready && first_block < 0) first_block = sent;
         if (got > 0 && got < 6 && !out_valid) gap_seen = 1'b1;
         if (out_valid && out_ready) begin
            m = model(32'hF0000000, got);
            chk($sformatf("bp_beat%0d", got), {31'd0, out_data, out_sticky}, {31'd0, m});
            got++;
         end
         if (in_valid && in_ready) sent++;
         prev_stall = out_valid && !out_ready;
         prev_d = out_data; prev_s = out_sticky; prev_z = out_zero;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_accepted_before_block", 64'(first_block), 64'd3);
      chk("bp_all_emitted", 64'(got), 64'd6);
      chk("bp_no_gaps", {63'd0, gap_seen}, 64'd0);

      // reset mid-flight: fill all three stages, then reset between edges
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hFFFFFFFF;
         in_cnt   = 5'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("mid_full_out_valid", {63'd0, out_valid}, 64'd1);
      chk("mid_full_in_ready",  {63'd0, in_ready}, 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_async_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_async_data",  {32'd0, out_data}, 64'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("mid_post_in_ready", {63'd0, in_ready}, 64'd1);
      send_one(32'h40000000, 5'd1, 1'b0, od, os, oz, lat);
      chk("mid_post_latency", 64'(lat), 64'd3);
      chk("mid_post_data",    {32'd0, od}, 64'h20000000);
      chk("mid_post_sticky",  {63'd0, os}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lzd_denorm_shift.md
Name: lzd_denorm_shift

Overview:
- Inverse-direction companion to the leading-zero detector tree.
- The detector produces a leading-zero count and a valid/non-zero flag. This block takes a normalized mantissa plus a shift count and right-shifts it back to fixed-point alignment.
- It also produces a sticky bit for downstream rounding.
- Three-stage pipelined barrel shifter with valid/ready handshake on both sides. It sits between the log/sqrt datapath and the Box-Muller output formatter.

Parameters:
- W, 32, mantissa width in bits; power of two, 8..64.
- SW, $clog2(W), shift-count width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  W  normalized mantissa.
- in_cnt  input  SW  right-shift amount, 0..W-1.
- in_zero  input  1  input is zero (inverted LZD v flag); overrides in_data.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts beat.
- out_data  output  W  in_data >> in_cnt, logical; zero-filled from MSB.
- out_sticky  output  1  OR of all bits shifted out.
- out_zero  output  1  registered copy of in_zero.

Behaviour:
- One clock domain: clk. Reset rst is asynchronous and active-high.
- While rst=1, all stage valid flags, data, count, sticky and zero registers clear to 0. This holds immediately, without waiting for a clock edge.
- Reset outputs: out_valid=0, out_data=0, out_sticky=0, out_zero=0. in_ready=1 once rst deasserts, because the pipeline is empty.
- Pipeline stages, each holding a valid flag, data, remaining count bits, sticky and zero:
  - S1: shift by in_cnt[SW-1:2]*4. Sticky starts as the OR of the bits shifted out.
  - S2: shift by in_cnt[1]*2. Sticky ORs in the bits shifted out.
  - S3: shift by in_cnt[0]. Sticky ORs in the bit shifted out. If zero=1, force data=0 and sticky=0.
- S3 registers drive out_* directly. There is no combinational path from in_data to out_data.
- Latency: 3 cycles from input acceptance (in_valid & in_ready at edge N) to out_valid at edge N+3, when not stalled.
- Throughput: 1 beat/cycle when out_ready=1.
- Stage advance rule, for stage k: adv_k = valid_k & (!valid_{k+1} | adv_{k+1}), with adv_3 = out_ready.
  - in_ready = !valid_1 | adv_1. This is combinational from out_ready through the chain; no skid buffer.
  - A stage loads from upstream when upstream advances.
  - A stage clears its valid flag when it advances and upstream does not.
  - A stage holds all of its contents when it is not advancing.
- Bubbles collapse: a beat moves into an empty downstream stage even while the output is stalled.
- Handshake rules:
  - out_valid, out_data, out_sticky and out_zero are stable while out_valid=1 & out_ready=0.
  - The bench may drive in_valid without regard to in_ready. A beat is consumed only when in_valid & in_ready.
- Simultaneous accept and emit on the same edge with a full pipeline: the beat is accepted, none is lost or duplicated, and order is preserved.
- Boundary conditions:
  - in_cnt=0: out_data=in_data, sticky=0.
  - in_cnt=W-1: only the MSB survives, in the LSB position.
  - in_zero=1: out_data=0, out_sticky=0, out_zero=1, regardless of in_data and in_cnt.
  - in_cnt is never out of range, because SW bits span exactly 0..W-1.
- Reset mid-operation: all in-flight beats are discarded and no partial beat is emitted. The first beat after reset follows the normal 3-cycle latency.

Test Plan:
- Reset: assert rst for 2 cycles, with in_valid=1 during reset -> out_valid=0, out_data=0x00000000, out_sticky=0. After deassert, in_ready=1 and nothing emerges.
- Identity: in_data=0x80000000, in_cnt=0, out_ready=1 -> 3 cycles later out_data=0x80000000, sticky=0, zero=0.
- Sticky from low bits: in_data=0xC0000001, in_cnt=5 -> out_data=0x06000000, sticky=1. Also in_data=0xC0000000, in_cnt=5 -> 0x06000000, sticky=0.
- Max shift and zero: in_data=0xFFFFFFFF, in_cnt=31 -> out_data=0x00000001, sticky=1. Then in_zero=1, in_data=0xFFFFFFFF, in_cnt=3 -> out_data=0, sticky=0, out_zero=1.
- Backpressure: stream 6 beats (cnt 0..5, data 0xF0000000) with out_ready=0 for cycles 2..8.
  - Exactly 3 beats are accepted before in_ready=0.
  - Outputs stay stable while stalled.
  - After release, all 6 emerge in order, each equal to 0xF0000000>>cnt, with no gaps once the pipeline is full.
- Reset mid-flight: fill all 3 stages, assert rst asynchronously between edges -> out_valid falls to 0 before the next edge. After release, a new beat in_data=0x40000000, in_cnt=1 yields 0x20000000 after exactly 3 cycles.
